// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- TX-side consumer of the UART byte FIFO.
//
// Pops bytes from a first-word-fall-through FIFO and serialises each one as
// an asynchronous 8N1 frame (LSB first) on tx, with optional even parity.
// Back-to-back frames are sent with no idle gap: the next pop happens in the
// last cycle of the last stop bit.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   tx_en         allows new frames to start; a running frame always completes
//   fifo_empty    FIFO empty flag
//   fifo_data     FIFO head byte (valid whenever fifo_empty=0)
//   fifo_rd       combinational pop strobe, one cycle per byte
//   tx            registered serial line, idle high
//   busy          high while a frame is on the line
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;    // data bit index, reused as stop-bit index
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic bit_last;
  logic stop_done;
  logic pop;

  assign bit_last  = (baud_q == BAUD_LAST);
  // Last cycle of the last stop bit: the frame ends on the coming edge, so a
  // pop here starts the next frame with zero idle gap.
  assign stop_done = (state_q == STOP) && bit_last && (bit_q == STOP_LAST);
  assign pop       = !rst && tx_en && !fifo_empty &&
                     ((state_q == IDLE) || stop_done);

  assign fifo_rd = pop;
  assign tx      = tx_q;
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
      end

      START: begin
        if (bit_last) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // tx is registered, so it takes the bit that becomes shift[0].
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_last) begin
          state_d = STOP;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // A pop overrides the normal STOP->IDLE exit and starts a fresh frame.
    if (pop) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = fifo_data;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: two instances (1 and 2 stop bits, 4 clks/bit)
// share all inputs. A frame-level reference model predicts tx/busy/fifo_rd
// every cycle; a vector table and directed sequences cover the corner cases.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L0 = (9 + 1 + PAR) * CPB;
  localparam int L1 = (9 + 2 + PAR) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       rd0, tx0, bsy0, rd1, tx1, bsy1;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(rd0), .tx(tx0), .busy(bsy0));

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(rd1), .tx(tx1), .busy(bsy1));

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: a frame is a bit list; tx = bit[pos / CPB].
  bit         m_act [2];
  int         m_pos [2];
  logic [12:0] m_f  [2];
  int         m_len [2];
  logic       s_rd [2];
  logic       s_tx [2];
  logic       s_bsy[2];

  function automatic logic [12:0] mk_frame(input logic [7:0] d);
    logic [12:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (PAR != 0) f[9] = ^d;
    return f;
  endfunction

  function automatic void chk(input string name, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Called once per cycle at the negedge: compare, snapshot, advance model.
  function automatic void model_check();
    logic g_rd, g_tx, g_bsy, e_rd, e_tx, e_bsy, opp;
    for (int k = 0; k < 2; k++) begin
      g_rd  = (k == 0) ? rd0  : rd1;
      g_tx  = (k == 0) ? tx0  : tx1;
      g_bsy = (k == 0) ? bsy0 : bsy1;
      e_tx  = m_act[k] ? m_f[k][m_pos[k] / CPB] : 1'b1;
      e_bsy = m_act[k];
      opp   = !m_act[k] || (m_pos[k] == m_len[k] - 1);
      e_rd  = !rst && tx_en && !fifo_empty && opp;
      vec_cnt++;
      if (g_rd !== e_rd || g_tx !== e_tx || g_bsy !== e_bsy) begin
        err_cnt++;
        $display("FAIL model[%0d]: rd/tx/busy got %b%b%b, expected %b%b%b (t=%0t)",
                 k, g_rd, g_tx, g_bsy, e_rd, e_tx, e_bsy, $time);
      end
      s_rd[k] = g_rd; s_tx[k] = g_tx; s_bsy[k] = g_bsy;
      if (rst) m_act[k] = 1'b0;
      else if (e_rd) begin
        m_act[k] = 1'b1; m_pos[k] = 0; m_f[k] = mk_frame(fifo_data);
      end else if (m_act[k]) begin
        if (m_pos[k] == m_len[k] - 1) m_act[k] = 1'b0;
        else m_pos[k]++;
      end
    end
  endfunction

  // One clock cycle: inputs set by the caller apply to this cycle; the
  // snapshots s_* hold this cycle's outputs on return (posedge + 1).
  task automatic nxt();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    fifo_empty = 1'b1;
    n = 0;
    do begin
      nxt();
      n++;
    end while ((s_bsy[0] || s_bsy[1]) && n < 200);
    if (n >= 200) chk("drain_timeout", n, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    int         low_np;   // tx-low cycles per frame, no parity
    int         low_p;    // tx-low cycles per frame, with parity
  } vec_t;

  task automatic run_vec(input vec_t v);
    int b0, b1, l0, l1, p, n;
    int exp_low;
    exp_low = (PAR != 0) ? v.low_p : v.low_np;
    drain();
    fifo_data = v.data; fifo_empty = 1'b0; tx_en = 1'b1;
    nxt();
    chk($sformatf("pop0_%02h", v.data), s_rd[0], 1);
    chk($sformatf("pop1_%02h", v.data), s_rd[1], 1);
    fifo_empty = 1'b1;
    b0 = 0; b1 = 0; l0 = 0; l1 = 0; p = 0; n = 0;
    do begin
      nxt();
      n++;
      b0 += s_bsy[0]; b1 += s_bsy[1];
      l0 += !s_tx[0]; l1 += !s_tx[1];
      p  += s_rd[0] + s_rd[1];
    end while ((s_bsy[0] || s_bsy[1]) && n < 200);
    chk($sformatf("busy_len0_%02h", v.data), b0, L0);
    chk($sformatf("busy_len1_%02h", v.data), b1, L1);
    chk($sformatf("tx_low0_%02h", v.data), l0, exp_low);
    chk($sformatf("tx_low1_%02h", v.data), l1, exp_low);
    chk($sformatf("extra_pops_%02h", v.data), p, 0);
  endtask

  vec_t tbl[7];

  initial begin
    int n, gap, drop, cnt;
    m_len[0] = L0; m_len[1] = L1;
    m_act[0] = 1'b0; m_act[1] = 1'b0;
    m_pos[0] = 0; m_pos[1] = 0;

    tbl[0] = '{8'hA5, 20, 24};
    tbl[1] = '{8'h00, 36, 40};
    tbl[2] = '{8'hFF,  4,  8};
    tbl[3] = '{8'h07, 24, 24};
    tbl[4] = '{8'h03, 28, 32};
    tbl[5] = '{8'h5A, 20, 24};
    tbl[6] = '{8'hC3, 20, 24};

    // Reset state
    rst = 1'b1; fifo_empty = 1'b0; tx_en = 1'b1; fifo_data = 8'h3C;
    nxt(); nxt();
    chk("rst_tx", s_tx[0], 1);
    chk("rst_busy", s_bsy[0], 0);
    chk("rst_rd", s_rd[0], 0);
    rst = 1'b0; fifo_empty = 1'b1;
    nxt();

    // Single frames, one per table entry
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Back-to-back: 0xA5 then 0x5A on the 1-stop-bit instance
    drain();
    fifo_data = 8'hA5; fifo_empty = 1'b0; tx_en = 1'b1;
    nxt();
    chk("b2b_pop1", s_rd[0], 1);
    fifo_data = 8'h5A;
    gap = 0; drop = 0; n = 0;
    while (n < 100) begin
      nxt();
      n++;
      if (!s_bsy[0]) drop++;
      if (s_rd[0]) begin gap = n; break; end
    end
    fifo_empty = 1'b1;
    chk("b2b_gap", gap, L0);
    chk("b2b_busy_drop", drop, 0);
    nxt();
    chk("b2b_start_tx", s_tx[0], 0);
    chk("b2b_start_busy", s_bsy[0], 1);

    // Empty FIFO: nothing happens; then tx_en=0 blocks pops
    drain();
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      nxt();
      cnt += s_rd[0] + s_rd[1] + s_bsy[0] + s_bsy[1] + !s_tx[0] + !s_tx[1];
    end
    chk("empty_idle_activity", cnt, 0);
    tx_en = 1'b0; fifo_empty = 1'b0; fifo_data = 8'h81;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      nxt();
      cnt += s_rd[0] + s_rd[1];
    end
    chk("tx_en_low_pops", cnt, 0);
    tx_en = 1'b1; fifo_empty = 1'b1;

    // Reset at cycle 15 of a 0xFF frame, then a full frame afterwards
    drain();
    fifo_data = 8'hFF; fifo_empty = 1'b0;
    nxt();
    fifo_empty = 1'b1;
    for (int i = 0; i < 14; i++) nxt();
    rst = 1'b1; fifo_empty = 1'b0;
    nxt();
    nxt();
    chk("midrst_tx", s_tx[0], 1);
    chk("midrst_busy", s_bsy[0], 0);
    chk("midrst_rd", s_rd[0], 0);
    chk("midrst_busy1", s_bsy[1], 0);
    rst = 1'b0; fifo_empty = 1'b1;
    run_vec(tbl[6]);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      fifo_empty = ($urandom_range(0, 3) == 0);
      tx_en      = ($urandom_range(0, 9) != 0);
      fifo_data  = 8'($urandom);
      rst        = ($urandom_range(0, 299) == 0);
      nxt();
    end
    rst = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
